cpu_trace_emitter: RTL and testbench

Serialises one CPU write-back record per request into the ASCII trace format consumed by the trace checker, one character per accepted cycle. Register records are `^<time>@<pc>: $<grf> <= <data>#`. Memory records are `^<time>@<pc>: *<addr> <= <data>#`. The block sits at the CPU's write-back stage and drives the character stream towards the checker or the UART path.

---
 rtl/cpu_trace_emitter.sv | 248 ++++++++++++++++++++++++
 tb/tb_cpu_trace_emitter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_emitter.sv
// cpu_trace_emitter
// Serialises one CPU write-back record per request into the ASCII trace
// format read by the trace checker, one character per accepted cycle:
//   register record: ^<time>@<pc>: $<grf> <= <data>#
//   memory record:   ^<time>@<pc>: *<addr> <= <data>#
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start           request one record (sampled only while idle)
//   kind            0 = register record, 1 = memory record
//   tstamp          decimal cycle stamp, 0..MAX_TIME ("time" is a reserved
//                   word in SystemVerilog, hence the name)
//   pc, grf, addr   fields of the record (grf used for kind=0, addr for kind=1)
//   data            written value
//   ready           downstream accepts the current character
//   char, valid     character stream
//   busy            a record is being converted or emitted
//   done            one-cycle pulse after the final '#' is accepted
//   err             one-cycle pulse when a start is rejected (tstamp too large)
module cpu_trace_emitter #(
    parameter int TIME_W   = 14,
    parameter int MAX_TIME = 9999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              kind,
    input  logic [TIME_W-1:0] tstamp,
    input  logic [31:0]       pc,
    input  logic [4:0]        grf,
    input  logic [31:0]       addr,
    input  logic [31:0]       data,
    input  logic              ready,
    output logic [7:0]        char,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_EMIT} state_t;

    // One entry per field of the record; multi-character fields walk 'sub'
    // downward so the most significant digit/nibble goes out first.
    typedef enum logic [3:0] {
        F_CARET, F_TIME, F_AT, F_PC, F_COLON, F_SP1, F_KIND, F_GRF,
        F_ADDR, F_SP2, F_LT, F_EQ, F_SP3, F_DATA, F_HASH
    } field_t;

    localparam int CNT_W = $clog2(TIME_W + 1);

    state_t            state, state_nx;
    field_t            field, field_nx;
    logic [2:0]        sub, sub_nx;
    logic              done_nx, err_nx;

    logic              kind_q;
    logic [31:0]       pc_q, addr_q, data_q;
    logic [4:0]        grf_q;
    logic [TIME_W-1:0] tbin;
    logic [15:0]       bcd, bcd_adj;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        tens, tens_c;
    logic [3:0]        ones, ones_c;
    logic [2:0]        tdig;
    logic              accept;
    logic              conv_last;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    assign accept    = (state == S_IDLE) && start && (tstamp <= TIME_W'(MAX_TIME));
    assign conv_last = (cnt == CNT_W'(TIME_W));
    assign valid     = (state == S_EMIT);
    assign busy      = (state != S_IDLE);

    // Number of significant decimal digits of the stamp (at least one).
    always_comb begin
        if (bcd[15:12] != 4'd0)     tdig = 3'd4;
        else if (bcd[11:8] != 4'd0) tdig = 3'd3;
        else if (bcd[7:4] != 4'd0)  tdig = 3'd2;
        else                        tdig = 3'd1;
    end

    // Double-dabble correction: bias every BCD digit >=5 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    // grf (0..31) split into tens/ones by compare/subtract.
    always_comb begin
        if (grf_q >= 5'd30) begin
            tens_c = 2'd3; ones_c = 4'(grf_q - 5'd30);
        end else if (grf_q >= 5'd20) begin
            tens_c = 2'd2; ones_c = 4'(grf_q - 5'd20);
        end else if (grf_q >= 5'd10) begin
            tens_c = 2'd1; ones_c = 4'(grf_q - 5'd10);
        end else begin
            tens_c = 2'd0; ones_c = grf_q[3:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            field <= F_CARET;
            sub   <= 3'd0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            field <= field_nx;
            sub   <= sub_nx;
            done  <= done_nx;
            err   <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        field_nx = field;
        sub_nx   = sub;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept)     state_nx = S_CONV;
                else if (start) err_nx   = 1'b1;
            end
            S_CONV: begin
                if (conv_last) begin
                    state_nx = S_EMIT;
                    field_nx = F_CARET;
                    sub_nx   = 3'd0;
                end
            end
            S_EMIT: begin
                if (ready) begin
                    case (field)
                        F_CARET: begin field_nx = F_TIME; sub_nx = tdig - 3'd1; end
                        F_TIME: begin
                            if (sub == 3'd0) field_nx = F_AT;
                            else             sub_nx   = sub - 3'd1;
                        end
                        F_AT:    begin field_nx = F_PC; sub_nx = 3'd7; end
                        F_PC: begin
                            if (sub == 3'd0) field_nx = F_COLON;
                            else             sub_nx   = sub - 3'd1;
                        end
                        F_COLON: field_nx = F_SP1;
                        F_SP1:   field_nx = F_KIND;
                        F_KIND: begin
                            if (kind_q) begin
                                field_nx = F_ADDR; sub_nx = 3'd7;
                            end else begin
                                field_nx = F_GRF;  sub_nx = {2'b00, tens != 2'd0};
                            end
                        end
                        F_GRF, F_ADDR: begin
                            if (sub == 3'd0) field_nx = F_SP2;
                            else             sub_nx   = sub - 3'd1;
                        end
                        F_SP2:   field_nx = F_LT;
                        F_LT:    field_nx = F_EQ;
                        F_EQ:    field_nx = F_SP3;
                        F_SP3:   begin field_nx = F_DATA; sub_nx = 3'd7; end
                        F_DATA: begin
                            if (sub == 3'd0) field_nx = F_HASH;
                            else             sub_nx   = sub - 3'd1;
                        end
                        F_HASH: begin
                            state_nx = S_IDLE;
                            field_nx = F_CARET;
                            done_nx  = 1'b1;
                        end
                        default: field_nx = F_CARET;
                    endcase
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Latched record fields and the conversion datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kind_q <= 1'b0;
            pc_q   <= 32'h0;
            addr_q <= 32'h0;
            data_q <= 32'h0;
            grf_q  <= 5'd0;
            tbin   <= '0;
            bcd    <= 16'h0;
            cnt    <= '0;
            tens   <= 2'd0;
            ones   <= 4'd0;
        end else begin
            if (accept) begin
                kind_q <= kind;
                pc_q   <= pc;
                addr_q <= addr;
                data_q <= data;
                grf_q  <= grf;
                tbin   <= tstamp;
                bcd    <= 16'h0;
                cnt    <= '0;
            end else if (state == S_CONV) begin
                if (cnt == '0) begin
                    tens <= tens_c;
                    ones <= ones_c;
                end
                if (!conv_last) begin
                    bcd  <= {bcd_adj[14:0], tbin[TIME_W-1]};
                    tbin <= {tbin[TIME_W-2:0], 1'b0};
                    cnt  <= cnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        char = 8'h00;
        if (state == S_EMIT) begin
            case (field)
                F_CARET: char = 8'h5E;
                F_TIME:  char = 8'h30 + {4'h0, bcd[{sub[1:0], 2'b00} +: 4]};
                F_AT:    char = 8'h40;
                F_PC:    char = hex(pc_q[{sub, 2'b00} +: 4]);
                F_COLON: char = 8'h3A;
                F_SP1, F_SP2, F_SP3: char = 8'h20;
                F_KIND:  char = kind_q ? 8'h2A : 8'h24;
                F_GRF:   char = 8'h30 + {4'h0, (sub[0] ? {2'b00, tens} : ones)};
                F_ADDR:  char = hex(addr_q[{sub, 2'b00} +: 4]);
                F_LT:    char = 8'h3C;
                F_EQ:    char = 8'h3D;
                F_DATA:  char = hex(data_q[{sub, 2'b00} +: 4]);
                F_HASH:  char = 8'h23;
                default: char = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
module tb_cpu_trace_emitter;
    localparam int TIME_W = 14;

    logic              clk = 1'b0;
    logic              reset, start, kind, ready;
    logic [TIME_W-1:0] tstamp;
    logic [31:0]       pc, addr, data;
    logic [4:0]        grf;
    logic [7:0]        char;
    logic              valid, busy, done, err;

    int checks = 0;
    int errors = 0;

    cpu_trace_emitter #(.TIME_W(TIME_W), .MAX_TIME(9999)) dut (
        .clk(clk), .reset(reset), .start(start), .kind(kind), .tstamp(tstamp),
        .pc(pc), .grf(grf), .addr(addr), .data(data), .ready(ready),
        .char(char), .valid(valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              kind;
        logic [TIME_W-1:0] t;
        logic [31:0]       pc;
        logic [4:0]        grf;
        logic [31:0]       addr;
        logic [31:0]       data;
        string             exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts a record at the current negedge and follows it to the done cycle.
    // inject_at >= 0: pulse a second start when that many chars were accepted.
    // abort_at  >= 0: assert reset after that many chars and return.
    task automatic run_record(input vec_t v, input string tag, input bit rnd,
                              input int inject_at, input int abort_at);
        int    lat, idx, cyc, hold_bad, drop, errs_seen, len;
        string got;
        bit    injected;
        len   = v.exp.len();
        kind  = v.kind; tstamp = v.t; pc = v.pc; grf = v.grf;
        addr  = v.addr; data = v.data;
        start = 1'b1; ready = 1'b0;
        @(negedge clk);
        // scramble inputs: the record must come from latched copies
        start = 1'b0; kind = ~v.kind; tstamp = 14'd4321; pc = ~v.pc;
        grf = ~v.grf; addr = ~v.addr; data = ~v.data;
        chk({tag, " busy after start"}, busy, 1);
        chk({tag, " done not set at start"}, done, 0);
        lat = 0;
        while (!valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " first valid latency"}, lat, TIME_W + 1);
        idx = 0; cyc = 0; hold_bad = 0; drop = 0; errs_seen = 0;
        got = ""; injected = 0;
        while (idx < len && cyc < 2000) begin
            if (abort_at >= 0 && idx == abort_at) break;
            start = 1'b0;
            if (inject_at >= 0 && !injected && idx == inject_at) begin
                start = 1'b1; tstamp = 14'd5; injected = 1;
            end
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (err) errs_seen++;
            if (!valid) drop++;
            else begin
                if (!ready && char !== 8'(v.exp[idx])) hold_bad++;
                if (ready) begin
                    got = $sformatf("%s%c", got, char);
                    idx++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (abort_at >= 0) begin
            #2 reset = 1'b1;
            #1;
            chk({tag, " valid drops on reset"}, valid, 0);
            chk({tag, " busy drops on reset"}, busy, 0);
            chk({tag, " char cleared on reset"}, char, 8'h00);
            ready = 1'b0;
            return;
        end
        checks++;
        if (got != v.exp) begin
            errors++;
            $display("FAIL %s stream: got \"%s\" expected \"%s\"", tag, got, v.exp);
        end
        chk({tag, " char count"}, idx, len);
        chk({tag, " char held while stalled"}, hold_bad, 0);
        chk({tag, " valid gaps mid-record"}, drop, 0);
        chk({tag, " no err during record"}, errs_seen, 0);
        chk({tag, " done after hash"}, done, 1);
        chk({tag, " valid low after hash"}, valid, 0);
        chk({tag, " busy low after hash"}, busy, 0);
        ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ready = 1'b0; kind = 1'b0; tstamp = '0;
        pc = '0; grf = '0; addr = '0; data = '0;

        vecs[0] = '{1'b0, 14'd5,    32'h00003000, 5'd1,  32'h0,        32'h12345678,
                    "^5@00003000: $1 <= 12345678#"};
        vecs[1] = '{1'b1, 14'd9999, 32'h00004ffc, 5'd0,  32'h00002ffc, 32'hdeadbeef,
                    "^9999@00004ffc: *00002ffc <= deadbeef#"};
        vecs[2] = '{1'b0, 14'd0,    32'h0000abcd, 5'd31, 32'h0,        32'h00000000,
                    "^0@0000abcd: $31 <= 00000000#"};
        vecs[3] = '{1'b0, 14'd10,   32'hffffffff, 5'd10, 32'h0,        32'ha0b0c0d0,
                    "^10@ffffffff: $10 <= a0b0c0d0#"};
        vecs[4] = '{1'b1, 14'd123,  32'h00000010, 5'd7,  32'h80000000, 32'h00000001,
                    "^123@00000010: *80000000 <= 00000001#"};
        vecs[5] = '{1'b0, 14'd1000, 32'h00400000, 5'd9,  32'h0,        32'h7fffffff,
                    "^1000@00400000: $9 <= 7fffffff#"};
        vecs[6] = '{1'b0, 14'd9,    32'h00000000, 5'd0,  32'h0,        32'hffffffff,
                    "^9@00000000: $0 <= ffffffff#"};

        repeat (3) @(negedge clk);
        chk("reset char", char, 8'h00);
        chk("reset valid", valid, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_record(vecs[i], $sformatf("vec%0d", i), 1'b0, -1, -1);
            @(negedge clk);
            chk($sformatf("vec%0d done one cycle", i), done, 0);
        end

        run_record(vecs[0], "random_ready", 1'b1, -1, -1);
        @(negedge clk);
        run_record(vecs[4], "random_ready_mem", 1'b1, -1, -1);
        @(negedge clk);

        // back-to-back: start in the done cycle is accepted
        run_record(vecs[1], "b2b_first", 1'b0, -1, -1);
        run_record(vecs[2], "b2b_second", 1'b0, -1, -1);
        @(negedge clk);

        // out-of-range stamp rejected
        tstamp = 14'd10000; kind = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("reject err pulse", err, 1);
        chk("reject valid", valid, 0);
        chk("reject busy", busy, 0);
        @(negedge clk);
        chk("reject err one cycle", err, 0);
        chk("reject stays idle", busy, 0);

        // second start mid-record is ignored
        run_record(vecs[1], "inject", 1'b0, 5, -1);
        @(negedge clk);
        chk("inject no restart", busy, 0);

        // reset after the 10th char, then a fresh record
        run_record(vecs[1], "abort", 1'b0, -1, 10);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("after reset no continuation valid", valid, 0);
        chk("after reset no continuation busy", busy, 0);
        run_record(vecs[0], "after_reset", 1'b0, -1, -1);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
